// File: rtl/timer_pkg.sv
// Shared types for the input-capture timer: edge selection and capture FSM states.
package timer_pkg;

  typedef enum logic [1:0] {
    RISE = 2'b00,
    FALL = 2'b01,
    BOTH = 2'b10
  } edge_sel_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    MEASURE = 2'b10
  } cap_state_e;

endpackage

// File: rtl/input_synchronizer.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
module input_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_sr <= '0;
    end else begin
      sync_sr <= {sync_sr[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_sr[SYNC_STAGES-1];

endmodule

// File: rtl/timer_capture.sv
// Input-capture timer: measures clk-cycle intervals between qualifying edges of an
// asynchronous event line and hands each result out over a valid/ready interface.
module timer_capture
  import timer_pkg::*;
#(
  parameter int               CNT_W       = 32,
  parameter logic [CNT_W-1:0] TIMEOUT     = CNT_W'(100_000_000),
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             event_in,
  input  edge_sel_e        edge_sel,
  output logic             capture_valid,
  input  logic             capture_ready,
  output logic [CNT_W-1:0] capture_period,
  output logic             capture_timeout,
  output logic             overrun,
  output logic             busy
);

  localparam logic [CNT_W-1:0] TO_LAST = TIMEOUT - 1'b1;

  cap_state_e       state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic             ev_sync, ev_hist, edge_hit;
  logic             res_new, res_timeout;
  logic [CNT_W-1:0] res_period;

  input_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (event_in),
    .q   (ev_sync)
  );

  always_comb begin
    edge_hit = ev_sync & ~ev_hist;
    case (edge_sel)
      FALL:    edge_hit = ~ev_sync & ev_hist;
      BOTH:    edge_hit = ev_sync ^ ev_hist;
      default: edge_hit = ev_sync & ~ev_hist;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      ev_hist <= 1'b0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      ev_hist <= ev_sync;
    end
  end

  // Count k at an edge means k+1 cycles since the previous edge was seen.
  always_comb begin
    state_next  = state;
    count_next  = count;
    res_new     = 1'b0;
    res_period  = '0;
    res_timeout = 1'b0;
    if (!enable) begin
      state_next = IDLE;
      count_next = '0;
    end else begin
      case (state)
        IDLE: state_next = ARMED;
        ARMED: begin
          if (edge_hit) begin
            count_next = '0;
            state_next = MEASURE;
          end
        end
        MEASURE: begin
          if (edge_hit) begin
            res_new    = 1'b1;
            res_period = count + 1'b1;
            count_next = '0;
          end else if (count == TO_LAST) begin
            res_new     = 1'b1;
            res_period  = TIMEOUT;
            res_timeout = 1'b1;
            count_next  = '0;
            state_next  = ARMED;
          end else begin
            count_next = count + 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          count_next = '0;
        end
      endcase
    end
  end

  // Handshake: a result transfers on any cycle with capture_valid && capture_ready;
  // period/timeout stay stable while valid is high and not accepted. A result
  // arriving while the old one is still unaccepted is dropped and flagged by overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      capture_valid   <= 1'b0;
      capture_period  <= '0;
      capture_timeout <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (res_new) begin
        if (!capture_valid || capture_ready) begin
          capture_valid   <= 1'b1;
          capture_period  <= res_period;
          capture_timeout <= res_timeout;
        end else begin
          overrun <= 1'b1;
        end
      end else if (capture_valid && capture_ready) begin
        capture_valid <= 1'b0;
      end
    end
  end

  assign busy = (state == MEASURE);

endmodule

// File: tb/tb_timer_capture.sv
// Self-checking bench for timer_capture: scoreboard of expected results popped on handshake.
module tb_timer_capture;
  import timer_pkg::*;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             event_in;
  edge_sel_e        edge_sel;
  logic             capture_valid;
  logic             capture_ready;
  logic [CNT_W-1:0] capture_period;
  logic             capture_timeout;
  logic             overrun;
  logic             busy;

  int checks  = 0;
  int errors  = 0;
  int ovr_cnt = 0;
  logic [CNT_W:0] exp_q[$];
  logic [CNT_W:0] exp_item;

  timer_capture #(
    .CNT_W       (CNT_W),
    .TIMEOUT     (32'd1000),
    .SYNC_STAGES (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .event_in        (event_in),
    .edge_sel        (edge_sel),
    .capture_valid   (capture_valid),
    .capture_ready   (capture_ready),
    .capture_period  (capture_period),
    .capture_timeout (capture_timeout),
    .overrun         (overrun),
    .busy            (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // ---------------- checking / scoreboard ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic to, input int unsigned period);
    exp_q.push_back({to, period[CNT_W-1:0]});
  endtask

  always @(negedge clk) begin
    if (!rst && overrun) ovr_cnt++;
    if (!rst && capture_valid && capture_ready) begin
      check("sb_pending", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        exp_item = exp_q.pop_front();
        check("result", 64'({capture_timeout, capture_period}), 64'(exp_item));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rearm(input edge_sel_e s);
    enable   = 1'b0;
    event_in = 1'b0;
    cyc(4);
    edge_sel = s;
    cyc(1);
    enable = 1'b1;
    cyc(4);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst           = 1'b1;
    enable        = 1'b0;
    event_in      = 1'b0;
    edge_sel      = RISE;
    capture_ready = 1'b1;
    cyc(3);
    check("rst_valid",   64'(capture_valid),   64'd0);
    check("rst_period",  64'(capture_period),  64'd0);
    check("rst_timeout", 64'(capture_timeout), 64'd0);
    check("rst_overrun", 64'(overrun),         64'd0);
    check("rst_busy",    64'(busy),            64'd0);
    rst = 1'b0;
    cyc(2);

    // 1: RISE every 50 cycles, latency 3 cycles from event_in
    rearm(RISE);
    event_in = 1'b1; cyc(25); event_in = 1'b0; cyc(25);
    for (int i = 0; i < 3; i++) begin
      push_exp(1'b0, 50);
      event_in = 1'b1;
      cyc(2);
      check("t1_lat_pre", 64'(capture_valid), 64'd0);
      cyc(1);
      check("t1_lat", 64'(capture_valid), 64'd1);
      check("t1_busy", 64'(busy), 64'd1);
      cyc(22); event_in = 1'b0; cyc(25);
    end
    check("t1_drained", 64'(exp_q.size()), 64'd0);

    // 2: BOTH, high 20 / low 30
    rearm(BOTH);
    event_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(20); push_exp(1'b0, 20); event_in = 1'b0;
      cyc(30); push_exp(1'b0, 30); event_in = 1'b1;
    end
    cyc(10);
    check("t2_drained", 64'(exp_q.size()), 64'd0);
    check("t2_overrun", 64'(ovr_cnt), 64'd0);

    // 3: timeout then re-arm
    rearm(RISE);
    push_exp(1'b1, 1000);
    event_in = 1'b1;
    cyc(10);
    check("t3_busy_meas", 64'(busy), 64'd1);
    cyc(1000);
    check("t3_busy_to", 64'(busy), 64'd0);
    check("t3_to_seen", 64'(exp_q.size()), 64'd0);
    event_in = 1'b0; cyc(10);
    event_in = 1'b1; cyc(30);
    event_in = 1'b0; cyc(30);
    push_exp(1'b0, 60);
    event_in = 1'b1; cyc(10);
    check("t3_drained", 64'(exp_q.size()), 64'd0);
    check("t3_busy_rearm", 64'(busy), 64'd1);

    // 4: back-pressure, overrun on later edges
    rearm(RISE);
    capture_ready = 1'b0;
    ovr_cnt = 0;
    event_in = 1'b1; cyc(20); event_in = 1'b0; cyc(20);
    push_exp(1'b0, 40);
    event_in = 1'b1; cyc(20); event_in = 1'b0; cyc(20);
    event_in = 1'b1; cyc(20); event_in = 1'b0; cyc(20);
    event_in = 1'b1; cyc(5);
    check("t4_held_valid",  64'(capture_valid),   64'd1);
    check("t4_held_period", 64'(capture_period),  64'd40);
    check("t4_held_to",     64'(capture_timeout), 64'd0);
    check("t4_ovr_cnt",     64'(ovr_cnt),         64'd2);
    capture_ready = 1'b1;
    cyc(1);
    capture_ready = 1'b0;
    check("t4_valid_drop", 64'(capture_valid), 64'd0);
    check("t4_drained", 64'(exp_q.size()), 64'd0);
    cyc(14); event_in = 1'b0; cyc(20);

    // 5: ready on the exact cycle a new result lands
    push_exp(1'b0, 40);
    event_in = 1'b1; cyc(3);
    check("t5_first_valid", 64'(capture_valid), 64'd1);
    cyc(17); event_in = 1'b0; cyc(20);
    push_exp(1'b0, 40);
    event_in = 1'b1; cyc(2);
    capture_ready = 1'b1;
    cyc(1);
    capture_ready = 1'b0;
    check("t5_valid_kept", 64'(capture_valid), 64'd1);
    check("t5_no_ovr",     64'(overrun),       64'd0);
    check("t5_one_popped", 64'(exp_q.size()),  64'd1);
    capture_ready = 1'b1;
    cyc(1);
    check("t5_ovr_cnt",  64'(ovr_cnt),       64'd2);
    check("t5_drained",  64'(exp_q.size()),  64'd0);
    check("t5_valid_lo", 64'(capture_valid), 64'd0);

    // 6: disable mid-measure, async reset with a held result, re-enable
    rearm(RISE);
    event_in = 1'b1; cyc(27);
    enable = 1'b0; cyc(2);
    check("t6_busy_off", 64'(busy), 64'd0);
    event_in = 1'b0; cyc(20);
    event_in = 1'b1; cyc(10);
    check("t6_no_result", 64'(capture_valid), 64'd0);
    event_in = 1'b0; cyc(4);
    enable = 1'b1; cyc(4);
    capture_ready = 1'b0;
    event_in = 1'b1; cyc(20); event_in = 1'b0; cyc(20);
    event_in = 1'b1; cyc(5);
    check("t6_pre_rst_valid", 64'(capture_valid), 64'd1);
    #2;
    rst = 1'b1;
    event_in = 1'b0;
    edge_sel = edge_sel_e'(2'b11);
    #1;
    check("t6_rst_valid",   64'(capture_valid),   64'd0);
    check("t6_rst_period",  64'(capture_period),  64'd0);
    check("t6_rst_timeout", 64'(capture_timeout), 64'd0);
    check("t6_rst_overrun", 64'(overrun),         64'd0);
    check("t6_rst_busy",    64'(busy),            64'd0);
    @(negedge clk);
    rst = 1'b0;
    capture_ready = 1'b1;
    cyc(5);
    event_in = 1'b1; cyc(22); event_in = 1'b0; cyc(23);
    push_exp(1'b0, 45);
    event_in = 1'b1; cyc(10);
    check("t6_drained", 64'(exp_q.size()), 64'd0);
    check("t6_ovr_cnt", 64'(ovr_cnt), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
